// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_pkg
// Purpose  : 640x480@60 timing constants, receiver FSM state encoding and
//            the sync polarity normalisation helper.
// Revision : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    localparam int CNT_W        = 10;

    localparam int VGA_H_TOTAL  = 800;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BACK   = 48;
    localparam int VGA_H_ACTIVE = 640;

    localparam int VGA_V_TOTAL  = 525;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BACK   = 33;
    localparam int VGA_V_ACTIVE = 480;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } sync_state_t;

    // Returns 1 when the raw pin level means "sync asserted".
    function automatic logic sync_asserted(input logic raw, input logic active_low);
        return raw ^ active_low;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge_detect
// Purpose  : Registers one sync input, normalises it to active-high and
//            flags the assertion edge (current sample asserted, previous not).
// Ports    : clk, reset (sync, active-high), sync_in (raw pin),
//            edge_pulse (combinational, valid for one cycle per assertion)
// Revision : 1.0 - initial release
// ============================================================================
module sync_edge_detect
    import vga_timing_pkg::*;
#(
    parameter logic ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic sync_in,
    output logic edge_pulse
);

    logic r_sample;
    logic r_prev;

    // Both history stages hold the normalised (deasserted = 0) level.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sample <= 1'b0;
            r_prev   <= 1'b0;
        end else begin
            r_sample <= sync_asserted(sync_in, ACTIVE_LOW);
            r_prev   <= r_sample;
        end
    end

    assign edge_pulse = r_sample & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/vga_sync_receiver.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_receiver
// Purpose  : Recovers pixel position from incoming VGA hsync/vsync, checks
//            line/frame lengths and reports lock state.
// Ports    : clk, reset (sync, active-high), vga_h_sync, vga_v_sync,
//            CounterX/CounterY (visible column/row), inDisplayArea, locked,
//            frame_start, h_err, v_err (1-cycle pulses), err_count
// Config   : define VGA_SYNC_STATS_EN to build the saturating error counter;
//            otherwise err_count is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module vga_sync_receiver
    import vga_timing_pkg::*;
#(
    parameter int H_TOTAL         = VGA_H_TOTAL,
    parameter int H_SYNC          = VGA_H_SYNC,
    parameter int H_BACK          = VGA_H_BACK,
    parameter int H_ACTIVE        = VGA_H_ACTIVE,
    parameter int V_TOTAL         = VGA_V_TOTAL,
    parameter int V_SYNC          = VGA_V_SYNC,
    parameter int V_BACK          = VGA_V_BACK,
    parameter int V_ACTIVE        = VGA_V_ACTIVE,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vga_h_sync,
    input  logic        vga_v_sync,
    output logic [9:0]  CounterX,
    output logic [9:0]  CounterY,
    output logic        inDisplayArea,
    output logic        locked,
    output logic        frame_start,
    output logic        h_err,
    output logic        v_err,
    output logic [15:0] err_count
);

    localparam logic [CNT_W-1:0] c_cnt_max  = '1;
    localparam logic [CNT_W-1:0] c_h_last   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_v_last   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_h_start  = CNT_W'(H_SYNC + H_BACK);
    localparam logic [CNT_W-1:0] c_h_end    = CNT_W'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [CNT_W-1:0] c_v_start  = CNT_W'(V_SYNC + V_BACK);
    localparam logic [CNT_W-1:0] c_v_end    = CNT_W'(V_SYNC + V_BACK + V_ACTIVE);

    logic             w_h_edge;
    logic             w_v_edge;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_vcnt;
    sync_state_t      r_state;
    sync_state_t      w_state_next;
    logic             w_h_bad;
    logic             w_v_bad;
    logic             w_report;
    logic             w_in_window;
    logic             r_h_err;
    logic             r_v_err;
    logic             r_frame_start;
    logic             r_in_display;
    logic [9:0]       r_counter_x;
    logic [9:0]       r_counter_y;

    sync_edge_detect #(.ACTIVE_LOW(SYNC_ACTIVE_LOW != 0)) u_h_edge (
        .clk        (clk),
        .reset      (reset),
        .sync_in    (vga_h_sync),
        .edge_pulse (w_h_edge)
    );

    sync_edge_detect #(.ACTIVE_LOW(SYNC_ACTIVE_LOW != 0)) u_v_edge (
        .clk        (clk),
        .reset      (reset),
        .sync_in    (vga_v_sync),
        .edge_pulse (w_v_edge)
    );

    // Position counters; both saturate so a dead input cannot wrap into a
    // plausible-looking count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else begin
            if (w_h_edge)
                r_hcnt <= '0;
            else if (r_hcnt != c_cnt_max)
                r_hcnt <= r_hcnt + 1'b1;

            if (w_v_edge)
                r_vcnt <= '0;
            else if (w_h_edge && (r_vcnt != c_cnt_max))
                r_vcnt <= r_vcnt + 1'b1;
        end
    end

    // A missing hsync is reported once, on the step into saturation.
    assign w_h_bad = (w_h_edge && (r_hcnt != c_h_last)) ||
                     (!w_h_edge && (r_hcnt == c_cnt_max - 1'b1));
    assign w_v_bad = w_v_edge && (r_vcnt != c_v_last);

    // While searching the counters are not yet aligned, so length errors
    // are meaningless and stay silent.
    assign w_report = (r_state != ST_SEARCH);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_SEARCH;
            r_h_err       <= 1'b0;
            r_v_err       <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_h_err       <= w_report && w_h_bad;
            r_v_err       <= w_report && w_v_bad;
            r_frame_start <= w_v_edge;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_SEARCH: begin
                if (w_v_edge)
                    w_state_next = ST_ACQUIRE;
            end
            ST_ACQUIRE: begin
                // Errors from earlier in the frame already sent us to
                // SEARCH; only the closing edge itself still needs vetting.
                if (r_h_err || r_v_err)
                    w_state_next = ST_SEARCH;
                else if (w_v_edge && !w_h_bad && !w_v_bad)
                    w_state_next = ST_LOCKED;
            end
            ST_LOCKED: begin
                if (r_h_err || r_v_err)
                    w_state_next = ST_SEARCH;
            end
            default: w_state_next = ST_SEARCH;
        endcase
    end

    assign w_in_window = (r_hcnt >= c_h_start) && (r_hcnt < c_h_end) &&
                         (r_vcnt >= c_v_start) && (r_vcnt < c_v_end);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_display <= 1'b0;
            r_counter_x  <= '0;
            r_counter_y  <= '0;
        end else begin
            r_in_display <= w_in_window && (r_state == ST_LOCKED);
            r_counter_x  <= w_in_window ? (r_hcnt - c_h_start) : '0;
            r_counter_y  <= w_in_window ? (r_vcnt - c_v_start) : '0;
        end
    end

`ifdef VGA_SYNC_STATS_EN
    logic [15:0] r_err_count;
    logic [1:0]  w_err_inc;
    logic [16:0] w_err_sum;

    assign w_err_inc = {1'b0, r_h_err} + {1'b0, r_v_err};
    assign w_err_sum = {1'b0, r_err_count} + {15'd0, w_err_inc};

    always_ff @(posedge clk) begin
        if (reset)
            r_err_count <= '0;
        else if (w_err_sum[16])
            r_err_count <= '1;
        else
            r_err_count <= w_err_sum[15:0];
    end

    assign err_count = r_err_count;
`else
    assign err_count = '0;
`endif

    assign CounterX      = r_counter_x;
    assign CounterY      = r_counter_y;
    assign inDisplayArea = r_in_display;
    assign locked        = (r_state == ST_LOCKED);
    assign frame_start   = r_frame_start;
    assign h_err         = r_h_err;
    assign v_err         = r_v_err;

endmodule
`default_nettype wire
